// File: rtl/mem_sync_pkg.sv
// Shared definitions for the memory handshake synchroniser: per-channel
// state encodings, default channel indices and common byte-mask constants.
package mem_sync_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_DONE = 1'b1
  } ch_state_e;

  localparam int CH_IM = 0;
  localparam int CH_DM = 1;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_ch_tracker.sv
// Single memory channel tracker. Issues the read strobe / write mask while
// the channel is still waiting, remembers a completion for the rest of the
// access window, and reports whether this channel lets the pipeline advance.
module mem_ch_tracker #(
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              mem_valid,
  input  logic              win_done,
  output logic              mem_r,
  output logic [MASK_W-1:0] mem_w,
  output logic              done,
  output logic              ch_ok
);
  import mem_sync_pkg::*;

  ch_state_e state_q;
  logic      done_q;
  logic      need;

  assign done_q = (state_q == S_DONE);
  assign need   = req_rd | req_wr;

  // Write wins when both requests are up; nothing is strobed once done.
  assign mem_r = req_rd & ~req_wr & ~done_q;
  assign mem_w = (req_wr & ~done_q) ? wr_mask : '0;
  assign done  = done_q | (need & mem_valid);
  assign ch_ok = ~need | done_q | mem_valid;

  // Channel FSM: a window release returns to S_REQ, otherwise latch a
  // completion that arrives while this channel actually has a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else if (win_done) begin
      state_q <= S_REQ;
    end else if (need && mem_valid) begin
      state_q <= S_DONE;
    end
  end

endmodule

// File: rtl/mem_access_sync.sv
// N-channel memory handshake synchroniser. Each channel is tracked by its own
// mem_ch_tracker; the pipeline is stalled until every requesting channel has
// completed within the current access window. A saturating counter records
// the total number of stalled cycles.
// Optional: define MEM_SYNC_TIMEOUT_EN to enable a sticky timeout flag that
// sets after TIMEOUT_CYC consecutive stall cycles; otherwise timeout_err is 0.
module mem_access_sync #(
  parameter int NUM_CH      = 2,
  parameter int MASK_W      = 4,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_rd,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*MASK_W-1:0] wr_mask,
  input  logic [NUM_CH-1:0]        mem_valid,
  output logic [NUM_CH-1:0]        mem_r,
  output logic [NUM_CH*MASK_W-1:0] mem_w,
  output logic [NUM_CH-1:0]        done_vec,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic                     timeout_err
);
  import mem_sync_pkg::*;

  logic [NUM_CH-1:0] ch_ok;
  logic              all_ok;

  assign all_ok = &ch_ok;
  assign stall  = ~all_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mem_ch_tracker #(
      .MASK_W (MASK_W)
    ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .req_rd    (req_rd[i]),
      .req_wr    (req_wr[i]),
      .wr_mask   (wr_mask[i*MASK_W +: MASK_W]),
      .mem_valid (mem_valid[i]),
      .win_done  (all_ok),
      .mem_r     (mem_r[i]),
      .mem_w     (mem_w[i*MASK_W +: MASK_W]),
      .done      (done_vec[i]),
      .ch_ok     (ch_ok[i])
    );
  end

  // Count every stalled cycle, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

`ifdef MEM_SYNC_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Track consecutive stall cycles and raise a sticky flag on the cycle the
  // run length reaches TIMEOUT_CYC; any non-stall cycle restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (stall) begin
      if (wait_cnt != WAIT_W'(TIMEOUT_CYC)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
        timeout_err <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sync.sv
// Directed self-checking bench for mem_access_sync with two channels, a
// 4-bit stall counter (so saturation is reachable) and an 8-cycle timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_mem_access_sync;

  localparam int NUM_CH      = 2;
  localparam int MASK_W      = 4;
  localparam int CNT_W       = 4;
  localparam int TIMEOUT_CYC = 8;

`ifdef MEM_SYNC_TIMEOUT_EN
  localparam logic TO_ON = 1'b1;
`else
  localparam logic TO_ON = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        req_rd;
  logic [NUM_CH-1:0]        req_wr;
  logic [NUM_CH*MASK_W-1:0] wr_mask;
  logic [NUM_CH-1:0]        mem_valid;
  logic [NUM_CH-1:0]        mem_r;
  logic [NUM_CH*MASK_W-1:0] mem_w;
  logic [NUM_CH-1:0]        done_vec;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;
  logic                     timeout_err;

  int checks;
  int passed;

  mem_access_sync #(
    .NUM_CH      (NUM_CH),
    .MASK_W      (MASK_W),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .wr_mask     (wr_mask),
    .mem_valid   (mem_valid),
    .mem_r       (mem_r),
    .mem_w       (mem_w),
    .done_vec    (done_vec),
    .stall       (stall),
    .stall_cnt   (stall_cnt),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_rd    = '0;
    req_wr    = '0;
    wr_mask   = '0;
    mem_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    req_rd = 2'b11;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL rst_stall: got %0h expected 1", stall); else passed++;
    checks++; if (mem_r !== 2'b11) $display("[TB] FAIL rst_mem_r: got %0h expected 3", mem_r); else passed++;
    checks++; if (stall_cnt !== 4'd0) $display("[TB] FAIL rst_cnt: got %0d expected 0", stall_cnt); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL rst_err: got %0h expected 0", timeout_err); else passed++;
    do_reset();
    @(negedge clk);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL rst_idle_stall: got %0h expected 0", stall); else passed++;
    checks++; if (done_vec !== 2'b00) $display("[TB] FAIL rst_done: got %0h expected 0", done_vec); else passed++;
    checks++; if (mem_w !== 8'h00) $display("[TB] FAIL rst_mem_w: got %0h expected 0", mem_w); else passed++;
  endtask

  task automatic test_two_reads();
    do_reset();
    req_rd = 2'b11;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL rd_stall_c0: got %0h expected 1", stall); else passed++;
    tick();
    mem_valid = 2'b01;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL rd_stall_c1: got %0h expected 1", stall); else passed++;
    checks++; if (mem_r !== 2'b11) $display("[TB] FAIL rd_mem_r_c1: got %0h expected 3", mem_r); else passed++;
    tick();
    mem_valid = 2'b00;
    @(negedge clk);
    checks++; if (mem_r !== 2'b10) $display("[TB] FAIL rd_mem_r_c2: got %0h expected 2", mem_r); else passed++;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL rd_stall_c2: got %0h expected 1", stall); else passed++;
    checks++; if (done_vec !== 2'b01) $display("[TB] FAIL rd_done_c2: got %0h expected 1", done_vec); else passed++;
    tick();
    mem_valid = 2'b10;
    @(negedge clk);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL rd_stall_c3: got %0h expected 0", stall); else passed++;
    checks++; if (done_vec !== 2'b11) $display("[TB] FAIL rd_done_c3: got %0h expected 3", done_vec); else passed++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd3) $display("[TB] FAIL rd_cnt: got %0d expected 3", stall_cnt); else passed++;
    checks++; if (done_vec !== 2'b00) $display("[TB] FAIL rd_done_after: got %0h expected 0", done_vec); else passed++;
  endtask

  task automatic test_read_write();
    do_reset();
    req_rd  = 2'b01;
    req_wr  = 2'b10;
    wr_mask = 8'h3F;
    @(negedge clk);
    checks++; if (mem_w !== 8'h30) $display("[TB] FAIL rw_mem_w_c0: got %0h expected 30", mem_w); else passed++;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL rw_stall_c0: got %0h expected 1", stall); else passed++;
    tick();
    @(negedge clk);
    checks++; if (mem_w !== 8'h30) $display("[TB] FAIL rw_mem_w_c1: got %0h expected 30", mem_w); else passed++;
    checks++; if (mem_r !== 2'b01) $display("[TB] FAIL rw_mem_r_c1: got %0h expected 1", mem_r); else passed++;
    tick();
    mem_valid = 2'b11;
    @(negedge clk);
    checks++; if (mem_w !== 8'h30) $display("[TB] FAIL rw_mem_w_c2: got %0h expected 30", mem_w); else passed++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL rw_stall_c2: got %0h expected 0", stall); else passed++;
    tick();
    mem_valid = 2'b00;
    @(negedge clk);
    checks++; if (done_vec !== 2'b00) $display("[TB] FAIL rw_done_c3: got %0h expected 0", done_vec); else passed++;
    checks++; if (mem_r !== 2'b01) $display("[TB] FAIL rw_mem_r_c3: got %0h expected 1", mem_r); else passed++;
    checks++; if (mem_w !== 8'h30) $display("[TB] FAIL rw_mem_w_c3: got %0h expected 30", mem_w); else passed++;
    checks++; if (stall_cnt !== 4'd2) $display("[TB] FAIL rw_cnt_c3: got %0d expected 2", stall_cnt); else passed++;
    tick();
    req_rd = 2'b11;
    @(negedge clk);
    checks++; if (mem_r !== 2'b01) $display("[TB] FAIL rw_write_wins: got %0h expected 1", mem_r); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_zero_wait();
    do_reset();
    req_rd    = 2'b01;
    mem_valid = 2'b11;
    @(negedge clk);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL zw_stall: got %0h expected 0", stall); else passed++;
    checks++; if (done_vec !== 2'b01) $display("[TB] FAIL zw_done: got %0h expected 1", done_vec); else passed++;
    checks++; if (mem_r !== 2'b01) $display("[TB] FAIL zw_mem_r: got %0h expected 1", mem_r); else passed++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd0) $display("[TB] FAIL zw_cnt: got %0d expected 0", stall_cnt); else passed++;
    checks++; if (done_vec !== 2'b00) $display("[TB] FAIL zw_done_after: got %0h expected 0", done_vec); else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_rd = 2'b11;
    tick();
    mem_valid = 2'b01;
    tick();
    mem_valid = 2'b00;
    @(negedge clk);
    checks++; if (mem_r !== 2'b10) $display("[TB] FAIL mr_mem_r_pre: got %0h expected 2", mem_r); else passed++;
    checks++; if (stall_cnt !== 4'd2) $display("[TB] FAIL mr_cnt_pre: got %0d expected 2", stall_cnt); else passed++;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (mem_r !== 2'b11) $display("[TB] FAIL mr_mem_r_rst: got %0h expected 3", mem_r); else passed++;
    checks++; if (stall_cnt !== 4'd0) $display("[TB] FAIL mr_cnt_rst: got %0d expected 0", stall_cnt); else passed++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL mr_stall_c3: got %0h expected 1", stall); else passed++;
    tick();
    mem_valid = 2'b10;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("[TB] FAIL mr_stall_c4: got %0h expected 1", stall); else passed++;
    tick();
    mem_valid = 2'b01;
    @(negedge clk);
    checks++; if (mem_r !== 2'b01) $display("[TB] FAIL mr_mem_r_c5: got %0h expected 1", mem_r); else passed++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL mr_stall_c5: got %0h expected 0", stall); else passed++;
    checks++; if (stall_cnt !== 4'd2) $display("[TB] FAIL mr_cnt_c5: got %0d expected 2", stall_cnt); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_duplicate_valid();
    do_reset();
    req_rd = 2'b11;
    tick();
    mem_valid = 2'b01;
    @(negedge clk);
    checks++; if (mem_r !== 2'b11) $display("[TB] FAIL dup_mem_r_c1: got %0h expected 3", mem_r); else passed++;
    tick();
    @(negedge clk);
    checks++; if (mem_r !== 2'b10) $display("[TB] FAIL dup_mem_r_c2: got %0h expected 2", mem_r); else passed++;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL dup_stall_c2: got %0h expected 1", stall); else passed++;
    tick();
    mem_valid = 2'b00;
    @(negedge clk);
    checks++; if (done_vec !== 2'b01) $display("[TB] FAIL dup_done_c3: got %0h expected 1", done_vec); else passed++;
    checks++; if (stall !== 1'b1) $display("[TB] FAIL dup_stall_c3: got %0h expected 1", stall); else passed++;
    tick();
    mem_valid = 2'b10;
    @(negedge clk);
    checks++; if (stall !== 1'b0) $display("[TB] FAIL dup_release: got %0h expected 0", stall); else passed++;
    checks++; if (done_vec !== 2'b11) $display("[TB] FAIL dup_done_c4: got %0h expected 3", done_vec); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout_saturate();
    do_reset();
    req_rd = 2'b11;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 7) begin
        checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL to_err_c7: got %0h expected 0", timeout_err); else passed++;
      end
      if (c == 8) begin
        checks++; if (timeout_err !== TO_ON) $display("[TB] FAIL to_err_c8: got %0h expected %0h", timeout_err, TO_ON); else passed++;
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (stall_cnt !== 4'hF) $display("[TB] FAIL sat_cnt: got %0d expected 15", stall_cnt); else passed++;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL to_idle_stall: got %0h expected 0", stall); else passed++;
    tick();
    tick();
    @(negedge clk);
    checks++; if (timeout_err !== TO_ON) $display("[TB] FAIL to_sticky: got %0h expected %0h", timeout_err, TO_ON); else passed++;
    checks++; if (stall_cnt !== 4'hF) $display("[TB] FAIL sat_hold: got %0d expected 15", stall_cnt); else passed++;
    do_reset();
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL to_cleared: got %0h expected 0", timeout_err); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_two_reads();
    test_read_write();
    test_zero_wait();
    test_mid_reset();
    test_duplicate_valid();
    test_timeout_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
